// File: rtl/bus_pkg.sv
// Shared bus definitions: FSM state encoding, idle-level constants and the
// default widths used by masters, the arbiter and the slave decoders.
package bus_pkg;

  localparam int DEF_ADDR_W = 30;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // A non-owner parks at these levels so OR/AND-combined bus lines are unaffected
  localparam logic [DEF_ADDR_W-1:0] BUS_ADDR_IDLE   = '0;
  localparam logic [DEF_DATA_W-1:0] BUS_DATA_IDLE   = '0;
  localparam logic                  BUS_STROBE_IDLE = 1'b1;
  localparam logic                  BUS_REQ_IDLE    = 1'b1;

endpackage

// File: rtl/bus_timeout_cnt.sv
// 8-bit wait counter for the ACCESS phase; expired is high once the count
// reaches LIMIT, and the count saturates there until cleared.
module bus_timeout_cnt #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LIMIT_C = 8'(LIMIT);

  logic [7:0] count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != LIMIT_C)) begin
      count_reg <= count_reg + 8'd1;
    end
  end

  assign expired = (count_reg == LIMIT_C);

endmodule

// File: rtl/bus_master_if.sv
// Master-side bus interface: requests the bus, issues one address strobe,
// waits for slave ready (or times out) and reports completion to the core.
module bus_master_if
  import bus_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_rw,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wr_data,
  output logic              core_busy,
  output logic              core_done,
  output logic              core_err,
  output logic [DATA_W-1:0] core_rd_data,
  output logic              bus_req_,
  input  logic              bus_grnt_,
  output logic              bus_as_,
  output logic              bus_rw,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic              bus_rdy_,
  input  logic [DATA_W-1:0] bus_rd_data
);

  localparam logic [ADDR_W-1:0] ADDR_IDLE = ADDR_W'(BUS_ADDR_IDLE);
  localparam logic [DATA_W-1:0] DATA_IDLE = DATA_W'(BUS_DATA_IDLE);

  state_t            state_reg;
  logic              rw_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wr_data_reg;
  logic              expired;

  // Counter runs only while waiting for ready in ACCESS; held at zero otherwise
  bus_timeout_cnt #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_reg != ACCESS),
    .enable  ((state_reg == ACCESS) && bus_rdy_),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      rw_reg       <= RW_READ;
      addr_reg     <= '0;
      wr_data_reg  <= '0;
      bus_req_     <= BUS_REQ_IDLE;
      bus_as_      <= BUS_STROBE_IDLE;
      bus_rw       <= RW_READ;
      bus_addr     <= ADDR_IDLE;
      bus_wr_data  <= DATA_IDLE;
      core_busy    <= 1'b0;
      core_done    <= 1'b0;
      core_err     <= 1'b0;
      core_rd_data <= '0;
    end else begin
      core_done <= 1'b0;
      core_err  <= 1'b0;
      case (state_reg)
        IDLE: begin
          // Grant seen here is the arbiter's power-up owner, not ours to use
          if (core_req) begin
            rw_reg      <= core_rw;
            addr_reg    <= core_addr;
            wr_data_reg <= core_wr_data;
            bus_req_    <= 1'b0;
            core_busy   <= 1'b1;
            state_reg   <= REQ;
          end
        end
        REQ: begin
          if (!bus_grnt_) begin
            bus_as_     <= 1'b0;
            bus_rw      <= rw_reg;
            bus_addr    <= addr_reg;
            bus_wr_data <= wr_data_reg;
            state_reg   <= ACCESS;
          end
        end
        ACCESS: begin
          bus_as_ <= BUS_STROBE_IDLE;
          // Slave ready wins over a timeout landing in the same cycle
          if (!bus_rdy_ || expired) begin
            if (!bus_rdy_) begin
              if (bus_rw == RW_READ) begin
                core_rd_data <= bus_rd_data;
              end
            end else begin
              core_err     <= 1'b1;
              core_rd_data <= '0;
            end
            core_done   <= 1'b1;
            core_busy   <= 1'b0;
            bus_req_    <= BUS_REQ_IDLE;
            bus_rw      <= RW_READ;
            bus_addr    <= ADDR_IDLE;
            bus_wr_data <= DATA_IDLE;
            state_reg   <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master_if.sv
// Self-checking bench for bus_master_if: scenario tasks check cycle timing
// inline, and a scoreboard checks every core_done against queued expectations.
module tb_bus_master_if;
  import bus_pkg::*;

  localparam int AW = 30;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          core_req = 1'b0;
  logic          core_rw = 1'b1;
  logic [AW-1:0] core_addr = '0;
  logic [DW-1:0] core_wr_data = '0;
  logic          core_busy, core_done, core_err;
  logic [DW-1:0] core_rd_data;
  logic          bus_req_, bus_as_, bus_rw;
  logic          bus_grnt_ = 1'b1;
  logic          bus_rdy_ = 1'b1;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wr_data;
  logic [DW-1:0] bus_rd_data = '0;

  typedef struct packed {
    logic [DW-1:0] rd;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  bus_master_if #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .core_req     (core_req),
    .core_rw      (core_rw),
    .core_addr    (core_addr),
    .core_wr_data (core_wr_data),
    .core_busy    (core_busy),
    .core_done    (core_done),
    .core_err     (core_err),
    .core_rd_data (core_rd_data),
    .bus_req_     (bus_req_),
    .bus_grnt_    (bus_grnt_),
    .bus_as_      (bus_as_),
    .bus_rw       (bus_rw),
    .bus_addr     (bus_addr),
    .bus_wr_data  (bus_wr_data),
    .bus_rdy_     (bus_rdy_),
    .bus_rd_data  (bus_rd_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_xfer(input logic [DW-1:0] rd, input logic err);
    sb.push_back({rd, err});
  endtask

  // Scoreboard: every completion must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (reset && core_done) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected_done: core_done=1 rd=%h err=%b, required no completion", core_rd_data, core_err);
      end else begin
        e = sb.pop_front();
        $display("xfer done: rd_data=%h err=%b (expected %h/%b)", core_rd_data, core_err, e.rd, e.err);
        if ({core_rd_data, core_err} !== {e.rd, e.err})
          $display("FAIL sb_result: rd=%h err=%b, required rd=%h err=%b", core_rd_data, core_err, e.rd, e.err);
        else passed++;
      end
    end
  end

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    checks++;
    if ({bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data, core_busy, core_done, core_err, core_rd_data}
        !== {1'b1, 1'b1, 1'b1, {AW{1'b0}}, {DW{1'b0}}, 3'b000, {DW{1'b0}}})
      $display("FAIL reset_values: req_=%b as_=%b rw=%b addr=%h wd=%h busy=%b done=%b err=%b rd=%h, required 1/1/1/0/0/0/0/0/0",
               bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data, core_busy, core_done, core_err, core_rd_data);
    else passed++;
    #2 reset = 1'b1;
    // Arbiter powers up granting master 0; with no request nothing may move
    bus_grnt_ = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({bus_req_, bus_as_, core_busy} !== 3'b110)
        $display("FAIL idle_grant_ignored: req_=%b as_=%b busy=%b, required 1/1/0", bus_req_, bus_as_, core_busy);
      else passed++;
    end
    bus_grnt_ = 1'b1;
  endtask

  task automatic test_read();
    core_req = 1'b1; core_rw = RW_READ; core_addr = 30'h0000_0040;
    expect_xfer(32'hDEAD_BEEF, 1'b0);
    step();  // cycle 1
    core_req = 1'b0;
    checks++;
    if ({bus_req_, core_busy} !== 2'b01)
      $display("FAIL read_req_c1: req_=%b busy=%b, required 0/1", bus_req_, core_busy);
    else passed++;
    step();  // cycle 2
    bus_grnt_ = 1'b0;
    checks++;
    if (bus_as_ !== 1'b1)
      $display("FAIL read_as_early_c2: as_=%b, required 1", bus_as_);
    else passed++;
    step();  // cycle 3
    checks++;
    if ({bus_as_, bus_rw, bus_addr} !== {1'b0, 1'b1, 30'h0000_0040})
      $display("FAIL read_strobe_c3: as_=%b rw=%b addr=%h, required 0/1/0000040", bus_as_, bus_rw, bus_addr);
    else passed++;
    bus_rdy_ = 1'b0; bus_rd_data = 32'hDEAD_BEEF;
    step();  // cycle 4
    checks++;
    if ({core_done, core_err, core_rd_data, bus_req_, bus_as_, bus_addr, core_busy}
        !== {1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1, {AW{1'b0}}, 1'b0})
      $display("FAIL read_done_c4: done=%b err=%b rd=%h req_=%b as_=%b addr=%h busy=%b, required 1/0/deadbeef/1/1/0/0",
               core_done, core_err, core_rd_data, bus_req_, bus_as_, bus_addr, core_busy);
    else passed++;
    bus_rdy_ = 1'b1; bus_rd_data = '0; bus_grnt_ = 1'b1;
    step();
    checks++;
    if (core_done !== 1'b0)
      $display("FAIL read_done_pulse: done=%b, required 0", core_done);
    else passed++;
  endtask

  task automatic test_write();
    core_req = 1'b1; core_rw = RW_WRITE; core_addr = 30'h0000_0100; core_wr_data = 32'h1234_5678;
    // Writes leave core_rd_data at the previous read value
    expect_xfer(32'hDEAD_BEEF, 1'b0);
    step();  // cycle 1
    core_req = 1'b0; core_wr_data = '0;
    step();  // cycle 2
    bus_grnt_ = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();  // ACCESS cycles 3..6
      checks++;
      if ({bus_addr, bus_wr_data, bus_rw, bus_as_, core_done}
          !== {30'h0000_0100, 32'h1234_5678, 1'b0, (k != 0), 1'b0})
        $display("FAIL write_access_%0d: addr=%h wd=%h rw=%b as_=%b done=%b, required 0000100/12345678/0/%b/0",
                 k, bus_addr, bus_wr_data, bus_rw, bus_as_, core_done, (k != 0));
      else passed++;
      if (k == 1) bus_grnt_ = 1'b1;  // arbiter drops grant mid-transfer
      if (k == 3) bus_rdy_ = 1'b0;
    end
    step();  // cycle 7
    checks++;
    if ({core_done, core_rd_data, bus_req_, bus_rw, bus_addr, bus_wr_data}
        !== {1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, {AW{1'b0}}, {DW{1'b0}}})
      $display("FAIL write_done: done=%b rd=%h req_=%b rw=%b addr=%h wd=%h, required 1/deadbeef/1/1/0/0",
               core_done, core_rd_data, bus_req_, bus_rw, bus_addr, bus_wr_data);
    else passed++;
    bus_rdy_ = 1'b1;
  endtask

  task automatic test_grant_wait();
    logic [DW-1:0] d;
    d = $urandom;
    core_req = 1'b1; core_rw = RW_READ; core_addr = 30'h0000_02AA;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 0) core_req = 1'b0;
      checks++;
      if ({bus_req_, bus_as_, core_busy, core_done} !== 4'b0110)
        $display("FAIL grant_wait_%0d: req_=%b as_=%b busy=%b done=%b, required 0/1/1/0",
                 i, bus_req_, bus_as_, core_busy, core_done);
      else passed++;
    end
    bus_grnt_ = 1'b0;
    step();
    checks++;
    if ({bus_as_, bus_addr} !== {1'b0, 30'h0000_02AA})
      $display("FAIL grant_wait_strobe: as_=%b addr=%h, required 0/00002aa", bus_as_, bus_addr);
    else passed++;
    bus_rdy_ = 1'b0; bus_rd_data = d;
    expect_xfer(d, 1'b0);
    step();
    checks++;
    if ({core_done, core_rd_data} !== {1'b1, d})
      $display("FAIL grant_wait_done: done=%b rd=%h, required 1/%h", core_done, core_rd_data, d);
    else passed++;
    bus_rdy_ = 1'b1; bus_grnt_ = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a[2];
    logic [DW-1:0] d[2];
    a[0] = 30'h0000_1000; a[1] = 30'h0000_2004;
    d[0] = $urandom; d[1] = $urandom;
    core_req = 1'b1; core_rw = RW_READ; core_addr = a[0];
    expect_xfer(d[0], 1'b0);
    for (int j = 0; j < 2; j++) begin
      step();
      core_req = 1'b0;
      checks++;
      if (bus_req_ !== 1'b0)
        $display("FAIL b2b_req_%0d: req_=%b, required 0", j, bus_req_);
      else passed++;
      bus_grnt_ = 1'b0;
      step();
      checks++;
      if ({bus_as_, bus_addr} !== {1'b0, a[j]})
        $display("FAIL b2b_strobe_%0d: as_=%b addr=%h, required 0/%h", j, bus_as_, bus_addr, a[j]);
      else passed++;
      bus_rdy_ = 1'b0; bus_rd_data = d[j];
      step();
      checks++;
      if ({core_done, bus_req_} !== 2'b11)
        $display("FAIL b2b_done_%0d: done=%b req_=%b, required 1/1", j, core_done, bus_req_);
      else passed++;
      bus_rdy_ = 1'b1; bus_grnt_ = 1'b1;
      if (j == 0) begin
        core_req = 1'b1; core_addr = a[1];
        expect_xfer(d[1], 1'b0);
      end
    end
    step();
    checks++;
    if ({bus_req_, core_busy} !== 2'b10)
      $display("FAIL b2b_idle: req_=%b busy=%b, required 1/0", bus_req_, core_busy);
    else passed++;
  endtask

  task automatic test_timeout();
    core_req = 1'b1; core_rw = RW_READ; core_addr = 30'h0000_0003;
    bus_rd_data = 32'hFFFF_FFFF;
    expect_xfer('0, 1'b1);
    step();
    core_req = 1'b0; bus_grnt_ = 1'b0;
    step();  // strobe cycle
    checks++;
    if (bus_as_ !== 1'b0)
      $display("FAIL timeout_strobe: as_=%b, required 0", bus_as_);
    else passed++;
    // Error lands TIMEOUT_CYC+1 cycles after the strobe cycle
    for (int k = 1; k <= TO; k++) begin
      step();
      checks++;
      if ({core_done, bus_as_, bus_req_} !== 3'b010)
        $display("FAIL timeout_wait_%0d: done=%b as_=%b req_=%b, required 0/1/0", k, core_done, bus_as_, bus_req_);
      else passed++;
    end
    step();
    checks++;
    if ({core_done, core_err, core_rd_data, bus_req_, bus_addr, core_busy}
        !== {1'b1, 1'b1, {DW{1'b0}}, 1'b1, {AW{1'b0}}, 1'b0})
      $display("FAIL timeout_done: done=%b err=%b rd=%h req_=%b addr=%h busy=%b, required 1/1/0/1/0/0",
               core_done, core_err, core_rd_data, bus_req_, bus_addr, core_busy);
    else passed++;
    bus_grnt_ = 1'b1; bus_rd_data = '0;
  endtask

  task automatic test_reset_mid();
    core_req = 1'b1; core_rw = RW_WRITE; core_addr = 30'h0000_0155; core_wr_data = 32'h0000_A5A5;
    step();
    core_req = 1'b0; bus_grnt_ = 1'b0;
    step();  // strobe cycle; a request while busy must be ignored
    checks++;
    if ({bus_as_, core_busy} !== 2'b01)
      $display("FAIL rst_mid_strobe: as_=%b busy=%b, required 0/1", bus_as_, core_busy);
    else passed++;
    core_req = 1'b1; core_addr = 30'h0000_0222;
    step();
    core_req = 1'b0;
    #3 reset = 1'b0;
    #1;
    checks++;
    if ({bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data, core_busy, core_done, core_err, core_rd_data}
        !== {1'b1, 1'b1, 1'b1, {AW{1'b0}}, {DW{1'b0}}, 3'b000, {DW{1'b0}}})
      $display("FAIL rst_mid_async: req_=%b as_=%b rw=%b addr=%h wd=%h busy=%b done=%b err=%b rd=%h, required reset values",
               bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data, core_busy, core_done, core_err, core_rd_data);
    else passed++;
    step();
    #2 reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({bus_req_, bus_as_, core_busy, core_done} !== 4'b1100)
        $display("FAIL rst_mid_no_reissue_%0d: req_=%b as_=%b busy=%b done=%b, required 1/1/0/0",
                 i, bus_req_, bus_as_, core_busy, core_done);
      else passed++;
    end
    bus_grnt_ = 1'b1;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_grant_wait();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    step();
    checks++;
    if (sb.size() != 0)
      $display("FAIL sb_drain: %0d transfers never completed, required 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
